// File: rtl/countdown_timer.sv
// Loadable multi-digit down-counter with hex/decade digit radix.
// Counts to zero once per enabled tick in RUN, pulses done at zero.
module countdown_timer #(
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  select,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  stop,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] dec_val, clamp_val;
  logic         running_q, running_d;
  logic         done_q, done_d;
  logic         borrow;
  logic [3:0]   dig, wrap;
  logic         at_zero, at_one;

  assign at_zero = (count_q == '0);
  assign at_one  = (count_q == W'(1));

  // Count minus one with the borrow rippling through all digits
  always_comb begin
    dec_val = count_q;
    borrow  = 1'b1;
    dig     = '0;
    wrap    = select ? 4'd9 : 4'd15;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count_q[4*i +: 4];
      if (borrow) begin
        if (dig == 4'd0) begin
          dec_val[4*i +: 4] = wrap;
        end else begin
          dec_val[4*i +: 4] = dig - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  // Load value with decade digits clamped to 9
  always_comb begin
    clamp_val = load_value;
    for (int i = 0; i < DIGITS; i++) begin
      if (select && (load_value[4*i +: 4] > 4'd9)) begin
        clamp_val[4*i +: 4] = 4'd9;
      end
    end
  end

  // Next state: load > stop > start > decrement
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (load) begin
      count_d = clamp_val;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, PAUSE: begin
          if (start && !stop && !at_zero) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (enable && !at_zero) begin
            count_d = dec_val;
            if (at_one) begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end
          end
        end
        EXPIRED: begin
          count_d = '0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    running_d = (state_d == RUN);
  end

  // State, count and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign count   = count_q;
  assign running = running_q;
  assign done    = done_q;

endmodule
